rf_onehot_wr: RTL and testbench

// - 8-entry general-purpose register file for the WISC datapath; direct consumer of the 3:8 write-select decoder.
// - Write port takes the decoder's 8-bit one-hot select; two read ports take 3-bit binary selects.
// - Sits between decode (operand read) and writeback (result write); one write and two reads per cycle.
// - Flags illegal (non-one-hot) write selects so the top-level err chain can report decoder/control faults.
//

---
 rtl/rf_onehot_wr_if.sv | 25 ++
 rtl/rf_onehot_wr.sv | 53 +++++
 tb/tb_rf_onehot_wr.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rf_onehot_wr_if.sv
// rf_onehot_wr_if -- register file access bundle.
// One write port (one-hot select from the 3:8 decoder) and two binary-select
// read ports, plus the illegal-select flag.
//   master : drives selects/write data and observes read data and err
//   slave  : the register file itself
interface rf_onehot_wr_if #(parameter int N = 16);
  logic [2:0]   read1RegSel;
  logic [2:0]   read2RegSel;
  logic [7:0]   writeRegSel;
  logic [N-1:0] writeData;
  logic         writeEn;
  logic [N-1:0] read1Data;
  logic [N-1:0] read2Data;
  logic         err;

  modport master (
    output read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
    input  read1Data, read2Data, err
  );

  modport slave (
    input  read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
    output read1Data, read2Data, err
  );
endinterface

// File: rtl/rf_onehot_wr.sv
// rf_onehot_wr -- 8 x N general-purpose register file, one-hot write select.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears R0..R7, beats any write
//   bus  : rf_onehot_wr_if.slave
//            read1RegSel/read2RegSel -> read1Data/read2Data (combinational)
//            writeEn/writeRegSel/writeData -> R[i] on next edge if select one-hot
//            err : writeEn with zero or multi-hot select (0 while rst)
// Optional build macro RF_BYPASS_EN: a legal same-cycle write to the register
// being read is forwarded to the read port (write-before-read). Without it,
// reads always return stored contents.
module rf_onehot_wr #(
  parameter int N = 16
) (
  input logic           clk,
  input logic           rst,
  rf_onehot_wr_if.slave bus
);

  logic [N-1:0] regs [8];
  logic [7:0]   sel_m1;
  logic         sel_onehot;
  logic         wr_ok;

  // x & (x-1) clears the lowest set bit: zero result with x!=0 means one-hot.
  assign sel_m1     = bus.writeRegSel - 8'd1;
  assign sel_onehot = (|bus.writeRegSel) && !(|(bus.writeRegSel & sel_m1));
  assign wr_ok      = bus.writeEn && sel_onehot;
  assign bus.err    = bus.writeEn && !sel_onehot && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < 8; i++)
        if (bus.writeRegSel[i]) regs[i] <= bus.writeData;
    end
  end

`ifdef RF_BYPASS_EN
  logic byp1, byp2;
  // wr_ok already implies a legal select, so indexing the one-hot by the
  // read select is an exact match test.
  assign byp1 = wr_ok && !rst && bus.writeRegSel[bus.read1RegSel];
  assign byp2 = wr_ok && !rst && bus.writeRegSel[bus.read2RegSel];
  assign bus.read1Data = byp1 ? bus.writeData : regs[bus.read1RegSel];
  assign bus.read2Data = byp2 ? bus.writeData : regs[bus.read2RegSel];
`else
  assign bus.read1Data = regs[bus.read1RegSel];
  assign bus.read2Data = regs[bus.read2RegSel];
`endif

endmodule

// File: tb/tb_rf_onehot_wr.sv
// Scoreboard bench for rf_onehot_wr: stimulus drives one cycle at a time and
// queues expected port values tagged with the cycle; a negedge monitor pops
// and compares them.
module tb_rf_onehot_wr;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;

  rf_onehot_wr_if #(.N(16)) bus ();

  rf_onehot_wr #(.N(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    int          port;   // 0 read1Data, 1 read2Data, 2 err
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  task automatic expect_val(input string nm, input int port, input logic [15:0] e);
    exp_t x;
    x.cyc = cyc; x.name = nm; x.port = port; x.exp = e;
    sb.push_back(x);
  endtask

  // Drive one cycle's inputs just after the rising edge.
  task automatic drv(input logic r, input logic we, input logic [7:0] sel,
                     input logic [15:0] d, input logic [2:0] s1, input logic [2:0] s2);
    @(posedge clk);
    #1;
    rst             = r;
    bus.writeEn     = we;
    bus.writeRegSel = sel;
    bus.writeData   = d;
    bus.read1RegSel = s1;
    bus.read2RegSel = s2;
  endtask

  task automatic wr(input int i, input logic [15:0] d);
    drv(1'b0, 1'b1, 8'd1 << i, d, 3'(i + 1), 3'(i + 1));
    expect_val("wr_err", 2, 16'h0000);
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    logic [15:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      case (x.port)
        0:       act = bus.read1Data;
        1:       act = bus.read2Data;
        default: act = {15'b0, bus.err};
      endcase
      vectors++;
      if (x.cyc != cyc || act !== x.exp) begin
        fails++;
        $display("FAIL %s cyc=%0d got=%h expected=%h", x.name, x.cyc, act, x.exp);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.writeEn = 1'b0; bus.writeRegSel = 8'h00; bus.writeData = 16'h0;
    bus.read1RegSel = 3'd0; bus.read2RegSel = 3'd0;
    drv(1'b1, 1'b0, 8'h00, 16'h0, 3'd0, 3'd0);
    drv(1'b1, 1'b0, 8'h00, 16'h0, 3'd0, 3'd0);

    // Preload all with FFFF, confirm, then a one-cycle reset clears them.
    for (int i = 0; i < 8; i++) wr(i, 16'hFFFF);
    drv(1'b0, 1'b0, 8'h00, 16'h0, 3'd0, 3'd7);
    expect_val("preload_r0", 0, 16'hFFFF);
    expect_val("preload_r7", 1, 16'hFFFF);
    drv(1'b1, 1'b0, 8'h00, 16'h0, 3'd0, 3'd7);
    expect_val("rst_err", 2, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, 1'b0, 8'h00, 16'h0, 3'(i), 3'(7 - i));
      expect_val("reset_r1", 0, 16'h0000);
      expect_val("reset_r2", 1, 16'h0000);
      expect_val("reset_err", 2, 16'h0000);
    end

    // Write/read all registers.
    for (int i = 0; i < 8; i++) wr(i, 16'h1110 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, 1'b0, 8'h00, 16'h0, 3'(i), 3'(7 - i));
      expect_val("sweep_r1", 0, 16'h1110 + 16'(i));
      expect_val("sweep_r2", 1, 16'h1110 + 16'(7 - i));
    end

    // Illegal selects suppress the write and raise err.
    wr(3, 16'hAAAA);
    wr(5, 16'h5555);
    drv(1'b0, 1'b1, 8'h28, 16'h1234, 3'd3, 3'd5);
    expect_val("ill_multi_err", 2, 16'h0001);
    expect_val("ill_multi_r3", 0, 16'hAAAA);
    expect_val("ill_multi_r5", 1, 16'h5555);
    drv(1'b0, 1'b1, 8'h00, 16'h1234, 3'd3, 3'd5);
    expect_val("ill_zero_err", 2, 16'h0001);
    expect_val("ill_after_r3", 0, 16'hAAAA);
    expect_val("ill_after_r5", 1, 16'h5555);
    drv(1'b0, 1'b0, 8'hFF, 16'h1234, 3'd3, 3'd5);
    expect_val("we0_err", 2, 16'h0000);
    drv(1'b0, 1'b0, 8'h00, 16'h0, 3'd3, 3'd5);
    expect_val("post_ill_r3", 0, 16'hAAAA);
    expect_val("post_ill_r5", 1, 16'h5555);
    expect_val("post_ill_err", 2, 16'h0000);

    // Same-cycle read-after-write on R2.
    wr(2, 16'h0001);
    drv(1'b0, 1'b1, 8'h04, 16'hBEEF, 3'd2, 3'd2);
`ifdef RF_BYPASS_EN
    expect_val("raw_same_r1", 0, 16'hBEEF);
    expect_val("raw_same_r2", 1, 16'hBEEF);
`else
    expect_val("raw_same_r1", 0, 16'h0001);
    expect_val("raw_same_r2", 1, 16'h0001);
`endif
    drv(1'b0, 1'b0, 8'h00, 16'h0, 3'd2, 3'd1);
    expect_val("raw_next_r1", 0, 16'hBEEF);
    expect_val("raw_next_r2", 1, 16'h1111);

    // Reset beats a concurrent write; err masked during reset.
    drv(1'b1, 1'b1, 8'h80, 16'hC0DE, 3'd7, 3'd7);
    expect_val("rstwr_err", 2, 16'h0000);
    expect_val("rstwr_nobyp", 0, 16'h1117);
    drv(1'b1, 1'b1, 8'h28, 16'hC0DE, 3'd7, 3'd2);
    expect_val("rst_ill_err", 2, 16'h0000);
    drv(1'b0, 1'b0, 8'h00, 16'h0, 3'd7, 3'd2);
    expect_val("rstwr_r7", 0, 16'h0000);
    expect_val("rstwr_r2", 1, 16'h0000);

    // Dual read of the same register.
    wr(6, 16'h7E7E);
    drv(1'b0, 1'b0, 8'h00, 16'h0, 3'd6, 3'd6);
    expect_val("dual_r1", 0, 16'h7E7E);
    expect_val("dual_r2", 1, 16'h7E7E);

    drv(1'b0, 1'b0, 8'h00, 16'h0, 3'd0, 3'd0);
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      fails = fails + sb.size();
      $display("FAIL scoreboard_drain got=%0d expected=0 pending", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
